// File: rtl/axis_packet_buffer.sv
// AXI-Stream packet buffer: circular memory with a registered
// first-word-fall-through output stage and optional store-and-forward gating.
module axis_packet_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int PACKET_MODE = 0,
    parameter int AFULL_LEVEL = (2 ** ADDR_WIDTH) - 4
) (
    input  logic                    s01_axis_aclk,
    input  logic                    s01_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    input  logic                    m01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast,
    output logic [ADDR_WIDTH:0]     occupancy,
    output logic [ADDR_WIDTH:0]     pkt_count,
    output logic                    almost_full,
    output logic                    oversize
);

    localparam int SW    = DATA_WIDTH / 8;
    localparam int EW    = DATA_WIDTH + SW + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam bit SAF   = (PACKET_MODE != 0);

    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL = CW'(AFULL_LEVEL);

    logic [EW-1:0]         mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;

    // occ counts every held word; mcnt/mlast count only words still in memory
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] pkt_q, pkt_d;
    logic [CW-1:0] mcnt_q, mcnt_d;
    logic [CW-1:0] mlast_q, mlast_d;

    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [SW-1:0]         m_strb_q, m_strb_d;
    logic                  af_q, af_d;
    logic                  ovs_q, ovs_d;
    logic                  drain_q, drain_d;
    logic                  mid_q, mid_d;

    logic          wr;
    logic          rd;
    logic          ld;
    logic          first_ok;
    logic [EW-1:0] head;
    logic          head_last;

    assign wr        = s01_axis_tvalid & s_ready_q;
    assign rd        = m_valid_q & m01_axis_tready;
    assign head      = mem_q[rptr_q];
    assign head_last = head[EW-1];

    // A packet's first beat may leave memory only once the whole packet is
    // stored, unless an oversize packet is being drained (the drain gate
    // blocks the next packet while the oversize tlast still sits in the output)
    assign first_ok = !SAF || mid_q || (mlast_q != '0) ||
                      (drain_q && !(m_valid_q && m_last_q));
    assign ld = (!m_valid_q || rd) && (mcnt_q != '0) && first_ok;

    // Storage array: no reset, contents are qualified by the counters
    always_ff @(posedge s01_axis_aclk) begin
        if (wr) begin
            mem_q[wptr_q] <= {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
        end
    end

    // Next-state for pointers, counters, output stage and drain control
    always_comb begin
        wptr_d    = wptr_q + ADDR_WIDTH'(wr);
        rptr_d    = rptr_q + ADDR_WIDTH'(ld);
        mcnt_d    = mcnt_q + CW'(wr) - CW'(ld);
        mlast_d   = mlast_q + CW'(wr & s01_axis_tlast) - CW'(ld & head_last);
        occ_d     = occ_q + CW'(wr) - CW'(rd);
        pkt_d     = pkt_q + CW'(wr & s01_axis_tlast) - CW'(rd & m_last_q);
        s_ready_d = (occ_d < FULL);
        af_d      = (occ_d >= AFULL);
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        m_strb_d  = m_strb_q;
        if (ld) begin
            m_valid_d = 1'b1;
            m_last_d  = head_last;
            m_strb_d  = head[EW-2 -: SW];
            m_data_d  = head[DATA_WIDTH-1:0];
        end else if (rd) begin
            m_valid_d = 1'b0;
        end
        mid_d   = ld ? !head_last : mid_q;
        drain_d = drain_q;
        ovs_d   = ovs_q;
        if (rd && m_last_q) begin
            drain_d = 1'b0;
        end
        // Full with no complete packet would deadlock: stream it out instead
        if (SAF && (occ_d == FULL) && (pkt_d == '0)) begin
            drain_d = 1'b1;
            ovs_d   = 1'b1;
        end
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
        if (!s01_axis_aresetn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            pkt_q     <= '0;
            mcnt_q    <= '0;
            mlast_q   <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_strb_q  <= '0;
            af_q      <= 1'b0;
            ovs_q     <= 1'b0;
            drain_q   <= 1'b0;
            mid_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            occ_q     <= occ_d;
            pkt_q     <= pkt_d;
            mcnt_q    <= mcnt_d;
            mlast_q   <= mlast_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_strb_q  <= m_strb_d;
            af_q      <= af_d;
            ovs_q     <= ovs_d;
            drain_q   <= drain_d;
            mid_q     <= mid_d;
        end
    end

    assign s01_axis_tready = s_ready_q;
    assign m01_axis_tvalid = m_valid_q;
    assign m01_axis_tlast  = m_last_q;
    assign m01_axis_tdata  = m_data_q;
    assign m01_axis_tstrb  = m_strb_q;
    assign occupancy       = occ_q;
    assign pkt_count       = pkt_q;
    assign almost_full     = af_q;
    assign oversize        = ovs_q;

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Bench for axis_packet_buffer: a streaming and a store-and-forward instance
// driven by directed and random traffic against a queue-based reference.
module tb_axis_packet_buffer;

    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int EW    = DW + SW + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] s_data  [2];
    logic [SW-1:0] s_strb  [2];
    logic          s_valid [2];
    logic          s_last  [2];
    logic          s_ready [2];
    logic          m_ready [2];
    logic [DW-1:0] m_data  [2];
    logic [SW-1:0] m_strb  [2];
    logic          m_valid [2];
    logic          m_last  [2];
    logic [AW:0]   occ     [2];
    logic [AW:0]   pkt     [2];
    logic          af      [2];
    logic          ovs     [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axis_packet_buffer #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .PACKET_MODE(g),
            .AFULL_LEVEL(AF)
        ) u_dut (
            .s01_axis_aclk   (clk),
            .s01_axis_aresetn(rst_n),
            .s01_axis_tdata  (s_data[g]),
            .s01_axis_tstrb  (s_strb[g]),
            .s01_axis_tvalid (s_valid[g]),
            .s01_axis_tlast  (s_last[g]),
            .s01_axis_tready (s_ready[g]),
            .m01_axis_tready (m_ready[g]),
            .m01_axis_tdata  (m_data[g]),
            .m01_axis_tstrb  (m_strb[g]),
            .m01_axis_tvalid (m_valid[g]),
            .m01_axis_tlast  (m_last[g]),
            .occupancy       (occ[g]),
            .pkt_count       (pkt[g]),
            .almost_full     (af[g]),
            .oversize        (ovs[g])
        );
    end

    typedef struct {
        logic [EW-1:0] beat;
        int            acc;
        bit            first;
    } ent_t;

    ent_t mq [2][$];
    bit   prev_last  [2];
    bit   ovs_e      [2];
    bit   drain_e    [2];
    int   drain_from [2];
    bit   last_acc   [2];
    int   edge_n;
    int   n_tests;
    int   n_fail;

    function automatic string tag(input string s, input int d);
        return $sformatf("%s[%0d]", s, d);
    endfunction

    task automatic chk(input string t, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask

    function automatic int lasts(input int d);
        int n = 0;
        for (int i = 0; i < mq[d].size(); i++)
            if (mq[d][i].beat[EW-1]) n++;
        return n;
    endfunction

    // Oldest word is visible one edge after it was stored; in packet mode a
    // first beat also waits for its packet's tlast (or an oversize drain).
    function automatic bit v_exp(input int d);
        if (mq[d].size() == 0) return 1'b0;
        if (mq[d][0].acc >= edge_n) return 1'b0;
        if (d == 0 || !mq[d][0].first) return 1'b1;
        if (drain_e[d] && drain_from[d] < edge_n) return 1'b1;
        for (int i = 0; i < mq[d].size(); i++)
            if (mq[d][i].beat[EW-1]) return mq[d][i].acc < edge_n;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            prev_last[d] = 1'b1;
            ovs_e[d]     = 1'b0;
            drain_e[d]   = 1'b0;
            drain_from[d] = 0;
            last_acc[d]  = 1'b0;
        end
    endtask

    task automatic check_state(input int d);
        int n;
        n = mq[d].size();
        chk(tag("occupancy", d), 64'(occ[d]), 64'(n));
        chk(tag("pkt_count", d), 64'(pkt[d]), 64'(lasts(d)));
        chk(tag("almost_full", d), 64'(af[d]), 64'(n >= AF));
        chk(tag("s_tready", d), 64'(s_ready[d]), 64'(n < DEPTH));
        chk(tag("oversize", d), 64'(ovs[d]), 64'(ovs_e[d]));
        chk(tag("m_tvalid", d), 64'(m_valid[d]), 64'(v_exp(d)));
    endtask

    task automatic reset_check();
        for (int d = 0; d < 2; d++) begin
            chk(tag("rst_s_tready", d), 64'(s_ready[d]), 64'd0);
            chk(tag("rst_m_tvalid", d), 64'(m_valid[d]), 64'd0);
            chk(tag("rst_m_tlast", d), 64'(m_last[d]), 64'd0);
            chk(tag("rst_m_tdata", d), 64'(m_data[d]), 64'd0);
            chk(tag("rst_m_tstrb", d), 64'(m_strb[d]), 64'd0);
            chk(tag("rst_occupancy", d), 64'(occ[d]), 64'd0);
            chk(tag("rst_pkt_count", d), 64'(pkt[d]), 64'd0);
            chk(tag("rst_almost_full", d), 64'(af[d]), 64'd0);
            chk(tag("rst_oversize", d), 64'(ovs[d]), 64'd0);
        end
    endtask

    // One clock: sample handshakes, advance model at the edge, check at negedge
    task automatic step();
        bit   acc [2];
        bit   del [2];
        ent_t e;
        for (int d = 0; d < 2; d++) begin
            acc[d] = s_valid[d] && s_ready[d];
            del[d] = m_valid[d] && m_ready[d];
            if (del[d]) begin
                if (mq[d].size() == 0)
                    chk(tag("spurious_beat", d), 64'(m_valid[d]), 64'd0);
                else
                    chk(tag("beat", d), 64'({m_last[d], m_strb[d], m_data[d]}),
                        64'(mq[d][0].beat));
            end
        end
        @(posedge clk);
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            if (del[d] && mq[d].size() > 0) begin
                if (mq[d][0].beat[EW-1]) drain_e[d] = 1'b0;
                void'(mq[d].pop_front());
            end
            if (acc[d]) begin
                e.beat  = {s_last[d], s_strb[d], s_data[d]};
                e.acc   = edge_n;
                e.first = prev_last[d];
                mq[d].push_back(e);
                prev_last[d] = s_last[d];
            end
            if (d == 1 && mq[d].size() == DEPTH && lasts(d) == 0) begin
                ovs_e[d] = 1'b1;
                if (!drain_e[d]) drain_from[d] = edge_n;
                drain_e[d] = 1'b1;
            end
            last_acc[d] = acc[d];
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_state(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int d, input logic [DW-1:0] data,
                        input logic last);
        s_valid[d] = 1'b1;
        s_data[d]  = data;
        s_strb[d]  = SW'($urandom);
        s_last[d]  = last;
        for (int k = 0; k < 64; k++) begin
            step();
            if (last_acc[d]) break;
        end
        if (!last_acc[d])
            chk(tag("send_timeout", d), 64'(last_acc[d]), 64'd1);
        s_valid[d] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        edge_n  = 0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0;
            s_data[d]  = '0;
            s_strb[d]  = '0;
            s_last[d]  = 1'b0;
            m_ready[d] = 1'b0;
        end
        model_clear();

        // Reset values, then tready rises on the first edge after release
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_check();
        rst_n = 1'b1;
        step();
        chk("tready_after_rst", 64'(s_ready[0]), 64'd1);

        // Streaming latency
        m_ready[0] = 1'b1;
        send(0, 32'h55, 1'b1);
        chk("lat_not_yet", 64'(m_valid[0]), 64'd0);
        step();
        chk("lat_valid", 64'(m_valid[0]), 64'd1);
        chk("lat_data", 64'(m_data[0]), 64'h55);
        chk("lat_last", 64'(m_last[0]), 64'd1);
        step();
        chk("lat_empty", 64'(occ[0]), 64'd0);

        // Backpressure holds the head word, then drains in order
        m_ready[0] = 1'b0;
        send(0, 32'h55, 1'b0);
        send(0, 32'h22, 1'b0);
        send(0, 32'h24, 1'b1);
        idle(2);
        chk("bp_occ", 64'(occ[0]), 64'd3);
        chk("bp_hold", 64'(m_data[0]), 64'h55);
        m_ready[0] = 1'b1;
        step();
        chk("bp_second", 64'(m_data[0]), 64'h22);
        step();
        chk("bp_third", 64'(m_data[0]), 64'h24);
        idle(2);

        // Full boundary: no write while full even with a concurrent read
        m_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 32'hA0 + i, i == 3);
        chk("full_tready", 64'(s_ready[0]), 64'd0);
        chk("full_occ", 64'(occ[0]), 64'd4);
        s_valid[0] = 1'b1;
        s_data[0]  = 32'hEE;
        s_last[0]  = 1'b1;
        m_ready[0] = 1'b1;
        step();
        chk("full_no_write", 64'(occ[0]), 64'd3);
        send(0, 32'hEE, 1'b1);
        idle(6);

        // Store-and-forward waits for tlast, then streams back-to-back
        m_ready[1] = 1'b1;
        send(1, 32'h11, 1'b0);
        chk("saf_wait1", 64'(m_valid[1]), 64'd0);
        send(1, 32'h12, 1'b0);
        chk("saf_wait2", 64'(m_valid[1]), 64'd0);
        send(1, 32'h13, 1'b1);
        chk("saf_wait3", 64'(m_valid[1]), 64'd0);
        step();
        chk("saf_b1", 64'(m_data[1]), 64'h11);
        step();
        chk("saf_b2", 64'(m_data[1]), 64'h12);
        step();
        chk("saf_b3", 64'(m_data[1]), 64'h13);
        step();
        chk("saf_done", 64'(m_valid[1]), 64'd0);

        // Oversize packet in store-and-forward mode
        m_ready[1] = 1'b0;
        for (int i = 0; i < 3; i++) send(1, 32'hB0 + i, 1'b0);
        chk("ovs_not_yet", 64'(ovs[1]), 64'd0);
        send(1, 32'hB3, 1'b0);
        chk("ovs_set", 64'(ovs[1]), 64'd1);
        chk("ovs_occ", 64'(occ[1]), 64'd4);
        m_ready[1] = 1'b1;
        send(1, 32'hB4, 1'b0);
        send(1, 32'hB5, 1'b1);
        idle(6);
        chk("ovs_drained", 64'(occ[1]), 64'd0);
        send(1, 32'hC0, 1'b0);
        chk("saf_resumed", 64'(m_valid[1]), 64'd0);
        send(1, 32'hC1, 1'b1);
        idle(4);

        // Random traffic on both instances
        for (int d = 0; d < 2; d++) s_valid[d] = 1'b0;
        for (int t = 0; t < 800; t++) begin
            for (int d = 0; d < 2; d++) begin
                if (!s_valid[d] || last_acc[d]) begin
                    s_valid[d] = ($urandom_range(0, 3) != 0);
                    s_data[d]  = $urandom;
                    s_strb[d]  = SW'($urandom);
                    s_last[d]  = ($urandom_range(0, d == 0 ? 3 : 4) == 0);
                end
                m_ready[d] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0;
            m_ready[d] = 1'b1;
        end
        idle(10);

        // Reset in the middle of operation discards everything at once
        m_ready[0] = 1'b0;
        send(0, 32'h31, 1'b0);
        send(0, 32'h32, 1'b1);
        step();
        chk("pre_rst_occ", 64'(occ[0]), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        reset_check();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_occ", 64'(occ[0]), 64'd0);
        m_ready[0] = 1'b1;
        send(0, 32'h77, 1'b1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
